// File: rtl/ky11_dmaarb_pkg.sv
// Shared constants and types for the KY11 DMA arbiter: cycle-type codes,
// Unibus address/data widths and the arbiter state encoding.
package ky11_pkg;

  localparam int AW = 18;
  localparam int DW = 16;

  localparam logic [1:0] DMA_DATI  = 2'd0;
  localparam logic [1:0] DMA_DATIP = 2'd1;
  localparam logic [1:0] DMA_DATO  = 2'd2;
  localparam logic [1:0] DMA_DATOB = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAITBUSY,
    WAITDONE,
    DONE
  } arb_state_t;

endpackage

// File: rtl/ky11_dmaarb_if.sv
// Arbiter <-> KY11 Unibus DMA engine connection; the arbiter is the master,
// the engine the slave.
interface ky11_dmaarb_if;
  import ky11_pkg::*;

  logic          dma_start;
  logic [AW-1:0] dma_addr;
  logic [1:0]    dma_ctrl;
  logic [DW-1:0] dma_wdata;
  logic          dma_busy;
  logic [DW-1:0] dma_rdata;
  logic          dma_timo;
  logic          dma_perr;

  modport master (
    output dma_start, dma_addr, dma_ctrl, dma_wdata,
    input  dma_busy, dma_rdata, dma_timo, dma_perr
  );

  modport slave (
    input  dma_start, dma_addr, dma_ctrl, dma_wdata,
    output dma_busy, dma_rdata, dma_timo, dma_perr
  );

endinterface

// File: rtl/ky11_dmaarb_rrpick.sv
// Combinational round-robin picker: returns the first masked request found
// searching upward from ptr+1, wrapping modulo NREQ.
module ky11_rrpick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  input  logic [NREQ-1:0] mask,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  logic [NREQ-1:0] cand;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
      assign cand[gi] = req[gi] & mask[gi];
    end
  endgenerate

  // Walk from the farthest candidate to the nearest so the nearest wins.
  always_comb begin
    logic [IW-1:0] j;
    valid = 1'b0;
    idx   = '0;
    j     = '0;
    for (int i = NREQ; i >= 1; i--) begin
      j = IW'((int'(ptr) + i) % NREQ);
      if (cand[j]) begin
        valid = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/ky11_dmaarb.sv
// Round-robin sharing of the KY11 Unibus DMA engine among NREQ requesters,
// with DATIP->DATO atomicity. Optional counters: KY11_DMAARB_STATS_EN.
module ky11_dmaarb
  import ky11_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int ACCTMO = 4
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic [NREQ-1:0]    req,
  input  logic [AW*NREQ-1:0] req_addr,
  input  logic [2*NREQ-1:0]  req_ctrl,
  input  logic [DW*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic [DW-1:0]      rdata,
  output logic               rtimo,
  output logic               rperr,
  input  logic               armlock,
`ifdef KY11_DMAARB_STATS_EN
  output logic [31:0]        stat_cycles,
  output logic [15:0]        stat_timos,
`endif
  ky11_dmaarb_if.master      dma
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(ACCTMO + 1);

  arb_state_t      state_reg;
  logic [IW-1:0]   idx_reg, rr_reg, lock_idx_reg;
  logic            lock_reg;
  logic [CW-1:0]   cnt_reg;
  logic [NREQ-1:0] gnt_reg, done_reg;
  logic            dma_start_reg;
  logic [AW-1:0]   addr_reg;
  logic [1:0]      ctrl_reg;
  logic [DW-1:0]   wdata_reg;
  logic [DW-1:0]   cap_rdata_reg, rdata_reg;
  logic            cap_timo_reg, cap_perr_reg, rtimo_reg, rperr_reg;

  logic [AW-1:0]   addr_arr  [NREQ];
  logic [1:0]      ctrl_arr  [NREQ];
  logic [DW-1:0]   wdata_arr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
      assign addr_arr[gi]  = req_addr[gi*AW +: AW];
      assign ctrl_arr[gi]  = req_ctrl[gi*2 +: 2];
      assign wdata_arr[gi] = req_wdata[gi*DW +: DW];
    end
  endgenerate

  logic            pick_valid, lock_hit, win_valid;
  logic [IW-1:0]   pick_idx, win_idx;

  ky11_rrpick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req   (req),
    .ptr   (rr_reg),
    .mask  ({NREQ{~armlock}}),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // A live rmw lock overrides round-robin; a stale one falls through to it.
  always_comb begin
    lock_hit  = lock_reg && req[lock_idx_reg];
    win_idx   = lock_hit ? lock_idx_reg : pick_idx;
    win_valid = !armlock && (lock_hit || pick_valid);
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      rr_reg        <= '0;
      lock_idx_reg  <= '0;
      lock_reg      <= 1'b0;
      cnt_reg       <= '0;
      gnt_reg       <= '0;
      done_reg      <= '0;
      dma_start_reg <= 1'b0;
      addr_reg      <= '0;
      ctrl_reg      <= '0;
      wdata_reg     <= '0;
      cap_rdata_reg <= '0;
      cap_timo_reg  <= 1'b0;
      cap_perr_reg  <= 1'b0;
      rdata_reg     <= '0;
      rtimo_reg     <= 1'b0;
      rperr_reg     <= 1'b0;
    end else begin
      dma_start_reg <= 1'b0;
      done_reg      <= '0;
      case (state_reg)
        IDLE: begin
          if (!armlock && lock_reg && !req[lock_idx_reg])
            lock_reg <= 1'b0;
          if (win_valid) begin
            idx_reg   <= win_idx;
            gnt_reg   <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
            addr_reg  <= addr_arr[win_idx];
            ctrl_reg  <= ctrl_arr[win_idx];
            wdata_reg <= wdata_arr[win_idx];
            state_reg <= START;
          end
        end
        START: begin
          dma_start_reg <= 1'b1;
          cnt_reg       <= '0;
          state_reg     <= WAITBUSY;
        end
        WAITBUSY: begin
          if (dma.dma_busy) begin
            state_reg <= WAITDONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
            // Engine never went busy: refused or held in INIT.
            if (cnt_reg == CW'(ACCTMO - 1)) begin
              cap_rdata_reg <= '0;
              cap_timo_reg  <= 1'b1;
              cap_perr_reg  <= 1'b0;
              state_reg     <= DONE;
            end
          end
        end
        WAITDONE: begin
          if (!dma.dma_busy) begin
            cap_rdata_reg <= dma.dma_rdata;
            cap_timo_reg  <= dma.dma_timo;
            cap_perr_reg  <= dma.dma_perr;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          done_reg     <= gnt_reg;
          gnt_reg      <= '0;
          rr_reg       <= idx_reg;
          rdata_reg    <= cap_rdata_reg;
          rtimo_reg    <= cap_timo_reg;
          rperr_reg    <= cap_perr_reg;
          lock_reg     <= (ctrl_reg == DMA_DATIP) && !cap_timo_reg;
          lock_idx_reg <= idx_reg;
          state_reg    <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign gnt           = gnt_reg;
  assign done          = done_reg;
  assign rdata         = rdata_reg;
  assign rtimo         = rtimo_reg;
  assign rperr         = rperr_reg;
  assign dma.dma_start = dma_start_reg;
  assign dma.dma_addr  = addr_reg;
  assign dma.dma_ctrl  = ctrl_reg;
  assign dma.dma_wdata = wdata_reg;

`ifdef KY11_DMAARB_STATS_EN
  logic [31:0] stat_cycles_reg;
  logic [15:0] stat_timos_reg;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      stat_cycles_reg <= '0;
      stat_timos_reg  <= '0;
    end else if (state_reg == DONE) begin
      if (stat_cycles_reg != 32'hFFFF_FFFF)
        stat_cycles_reg <= stat_cycles_reg + 1'b1;
      if (cap_timo_reg && stat_timos_reg != 16'hFFFF)
        stat_timos_reg <= stat_timos_reg + 1'b1;
    end
  end

  assign stat_cycles = stat_cycles_reg;
  assign stat_timos  = stat_timos_reg;
`endif

endmodule

// File: tb/tb_ky11_dmaarb.sv
// Self-checking bench for ky11_dmaarb: behavioural DMA engine, scoreboard of
// expected completions, a vector table plus hand-written multi-cycle sequences.
module tb_ky11_dmaarb;
  import ky11_pkg::*;

  localparam int NREQ   = 4;
  localparam int ACCTMO = 4;

  logic               clk = 1'b0;
  logic               RESET = 1'b1;
  logic [NREQ-1:0]    req = '0;
  logic [AW*NREQ-1:0] req_addr = '0;
  logic [2*NREQ-1:0]  req_ctrl = '0;
  logic [DW*NREQ-1:0] req_wdata = '0;
  logic [NREQ-1:0]    gnt, done;
  logic [DW-1:0]      rdata;
  logic               rtimo, rperr;
  logic               armlock = 1'b0;

  ky11_dmaarb_if dif();

  ky11_dmaarb #(.NREQ(NREQ), .ACCTMO(ACCTMO)) dut (
    .CLOCK     (clk),
    .RESET     (RESET),
    .req       (req),
    .req_addr  (req_addr),
    .req_ctrl  (req_ctrl),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .done      (done),
    .rdata     (rdata),
    .rtimo     (rtimo),
    .rperr     (rperr),
    .armlock   (armlock),
    .dma       (dif)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [1:0]  ctrl;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    bit          timo;
    bit          perr;
    int          lat;
  } exp_t;

  typedef struct {
    int          idx;
    logic [1:0]  ctrl;
    logic [17:0] addr;
    logic [15:0] wdata;
    bit          never;
    int          lat;
    logic [15:0] rdata;
    bit          timo;
    bit          perr;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[8];

  int checks = 0, failures = 0, done_cnt = 0, cyc = 0, start_cnt = 0;

  // engine model configuration (written by the driver only)
  bit          eng_never = 0, eng_fixed = 1, eng_abort = 0, eng_timo = 0, eng_perr = 0;
  int          eng_lat = 2;
  logic [15:0] eng_rdata = '0;
  // engine model state (written by the engine only)
  int          eng_cnt = 0;
  logic [17:0] st_addr = '0;
  logic [1:0]  st_ctrl = '0;
  logic [15:0] st_wdata = '0;

  function automatic logic [15:0] rd_of(logic [17:0] a);
    return a[15:0] ^ 16'h5A3C ^ {14'b0, a[17:16]};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural KY11 engine: goes busy on the start pulse, idles after eng_lat cycles.
  always @(negedge clk) begin
    if (eng_abort) begin
      eng_cnt      = 0;
      dif.dma_busy = 1'b0;
    end else if (eng_cnt > 0) begin
      eng_cnt = eng_cnt - 1;
      if (eng_cnt == 0) begin
        dif.dma_busy  = 1'b0;
        dif.dma_rdata = eng_fixed ? eng_rdata : rd_of(st_addr);
        dif.dma_timo  = eng_timo;
        dif.dma_perr  = eng_perr;
      end
    end else if (dif.dma_start) begin
      start_cnt = start_cnt + 1;
      st_addr   = dif.dma_addr;
      st_ctrl   = dif.dma_ctrl;
      st_wdata  = dif.dma_wdata;
      if (!eng_never) begin
        dif.dma_busy  = 1'b1;
        dif.dma_rdata = 16'hDEAD;
        dif.dma_timo  = 1'b0;
        dif.dma_perr  = 1'b0;
        eng_cnt       = eng_lat;
      end
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
    end
  endtask

  task automatic push_exp(int i, logic [1:0] c, logic [17:0] a, logic [15:0] w,
                          logic [15:0] r, bit t, bit p, int l);
    exp_t e;
    e.idx = i; e.ctrl = c; e.addr = a; e.wdata = w;
    e.rdata = r; e.timo = t; e.perr = p; e.lat = l;
    sb.push_back(e);
  endtask

  task automatic set_slot(int i, logic [1:0] c, logic [17:0] a, logic [15:0] w);
    req_addr[i*AW +: AW]  = a;
    req_ctrl[i*2 +: 2]    = c;
    req_wdata[i*DW +: DW] = w;
  endtask

  task automatic cycles(int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_dones(int target, int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (done_cnt < target) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=%0d required=%0d", done_cnt, target);
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1; req = '0; armlock = 1'b0; eng_abort = 1'b1;
    cycles(3);
    RESET = 1'b0; eng_abort = 1'b0;
  endtask

  // Pops one expectation per done pulse and checks result, engine request and timing.
  task automatic monitor();
    logic [NREQ-1:0] prev_gnt = '0;
    int gnt_cyc = 0, start_cyc = 0, nstarts = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (RESET) begin
        prev_gnt = '0;
      end else begin
        if (gnt != 0 && prev_gnt == 0) begin
          gnt_cyc = cyc;
          nstarts = 0;
        end
        if (dif.dma_start) begin
          nstarts++;
          start_cyc = cyc;
        end
        prev_gnt = gnt;
        if (done != 0) begin
          done_cnt++;
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual=%b required=none", done);
          end else begin
            e = sb.pop_front();
            $display("done idx=%0d ctrl=%0d addr=%o rdata=%o rtimo=%0d rperr=%0d lat=%0d",
                     e.idx, e.ctrl, e.addr, rdata, rtimo, rperr, cyc - gnt_cyc);
            check("done_vec", 32'(done), 32'(1) << e.idx);
            check("rdata", 32'(rdata), 32'(e.rdata));
            check("rtimo", 32'(rtimo), 32'(e.timo));
            check("rperr", 32'(rperr), 32'(e.perr));
            check("gnt_at_done", 32'(gnt), 32'd0);
            check("dma_addr", 32'(st_addr), 32'(e.addr));
            check("dma_ctrl", 32'(st_ctrl), 32'(e.ctrl));
            check("dma_wdata", 32'(st_wdata), 32'(e.wdata));
            check("start_pulses", 32'(nstarts), 32'd1);
            check("gnt_to_start", 32'(start_cyc - gnt_cyc), 32'd1);
            check("gnt_to_done", 32'(cyc - gnt_cyc), 32'(e.lat));
          end
        end
      end
    end
  endtask

  initial begin
    int base, s0, n;
    vec_t v;

    fork
      monitor();
    join_none

    do_reset();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_rtimo", 32'(rtimo), 32'd0);
    check("rst_rperr", 32'(rperr), 32'd0);
    check("rst_start", 32'(dif.dma_start), 32'd0);
    check("rst_addr", 32'(dif.dma_addr), 32'd0);

    //            idx ctrl       addr          wdata     never lat rdata       timo perr
    tbl[0] = '{0, DMA_DATI,  18'o777570, 16'h0000, 0, 20, 16'o123456, 0, 0};
    tbl[1] = '{3, DMA_DATO,  18'o172340, 16'hBEEF, 0,  3, 16'h0000,   0, 0};
    tbl[2] = '{2, DMA_DATOB, 18'h3FFFF,  16'h00FF, 0,  1, 16'h0001,   0, 0};
    tbl[3] = '{1, DMA_DATI,  18'h00001,  16'h0000, 0,  5, 16'hFFFF,   0, 1};
    tbl[4] = '{0, DMA_DATI,  18'o160000, 16'h0000, 0,  2, 16'h1234,   1, 0};
    tbl[5] = '{2, DMA_DATI,  18'o777560, 16'h0000, 1,  0, 16'hAAAA,   0, 1};
    tbl[6] = '{3, DMA_DATIP, 18'o001000, 16'h0000, 0,  2, 16'h5555,   0, 0};
    tbl[7] = '{1, DMA_DATO,  18'o002000, 16'h8001, 0,  4, 16'hC0DE,   0, 0};

    for (int i = 0; i < 8; i++) begin
      v = tbl[i];
      set_slot(v.idx, v.ctrl, v.addr, v.wdata);
      eng_fixed = 1; eng_never = v.never; eng_lat = v.lat;
      eng_rdata = v.rdata; eng_timo = v.timo; eng_perr = v.perr;
      if (v.never)
        push_exp(v.idx, v.ctrl, v.addr, v.wdata, 16'h0, 1, 0, ACCTMO + 2);
      else
        push_exp(v.idx, v.ctrl, v.addr, v.wdata, v.rdata, v.timo, v.perr, v.lat + 3);
      base = done_cnt;
      req = NREQ'(1) << v.idx;
      wait_dones(base + 1, 200);
      req = '0;
      cycles(2);
    end
    eng_never = 0;

    cycles(5);
    check("rdata_hold", 32'(rdata), 32'(tbl[7].rdata));
    check("rtimo_hold", 32'(rtimo), 32'd0);

    // all four requesting after reset: round-robin from rr=0
    do_reset();
    eng_fixed = 0; eng_lat = 2; eng_timo = 0; eng_perr = 0;
    for (int i = 0; i < NREQ; i++)
      set_slot(i, DMA_DATI, 18'o100000 + 18'(i * 8), 16'(i));
    for (int k = 0; k < NREQ; k++) begin
      n = (k + 1) % NREQ;
      push_exp(n, DMA_DATI, 18'o100000 + 18'(n * 8), 16'(n),
               rd_of(18'o100000 + 18'(n * 8)), 0, 0, 5);
    end
    base = done_cnt;
    req = '1;
    wait_dones(base + 4, 200);
    req = '0;
    cycles(2);

    // DATIP/DATO pair on requester 1 stays atomic against pending requester 2
    do_reset();
    set_slot(1, DMA_DATIP, 18'o004000, 16'h0000);
    set_slot(2, DMA_DATO,  18'o006000, 16'h2222);
    push_exp(1, DMA_DATIP, 18'o004000, 16'h0000, rd_of(18'o004000), 0, 0, 5);
    push_exp(1, DMA_DATO,  18'o004000, 16'h1111, rd_of(18'o004000), 0, 0, 5);
    push_exp(2, DMA_DATO,  18'o006000, 16'h2222, rd_of(18'o006000), 0, 0, 5);
    base = done_cnt;
    req = 4'b0110;
    wait_dones(base + 1, 100);
    set_slot(1, DMA_DATO, 18'o004000, 16'h1111);
    wait_dones(base + 2, 100);
    req = 4'b0100;
    wait_dones(base + 3, 100);
    req = '0;
    cycles(2);

    // armlock blocks grants; release grants within one cycle
    do_reset();
    set_slot(0, DMA_DATI, 18'o010000, 16'h0);
    set_slot(1, DMA_DATI, 18'o012000, 16'h0);
    armlock = 1'b1;
    s0 = start_cnt;
    req = 4'b0011;
    cycles(10);
    check("armlock_gnt", 32'(gnt), 32'd0);
    check("armlock_starts", 32'(start_cnt - s0), 32'd0);
    push_exp(1, DMA_DATI, 18'o012000, 16'h0, rd_of(18'o012000), 0, 0, 5);
    push_exp(0, DMA_DATI, 18'o010000, 16'h0, rd_of(18'o010000), 0, 0, 5);
    base = done_cnt;
    armlock = 1'b0;
    cycles(1);
    check("unlock_gnt", 32'(gnt), 32'b0010);
    wait_dones(base + 2, 100);
    req = '0;
    cycles(2);

    // RESET during WAITDONE: no done, grant drops, rr back to 0
    do_reset();
    set_slot(2, DMA_DATI, 18'o020000, 16'h0);
    push_exp(2, DMA_DATI, 18'o020000, 16'h0, rd_of(18'o020000), 0, 0, 5);
    base = done_cnt;
    req = 4'b0100;
    wait_dones(base + 1, 100);
    req = '0;
    cycles(2);
    set_slot(0, DMA_DATI, 18'o030000, 16'h0);
    eng_lat = 30;
    s0 = start_cnt;
    n = 0;
    req = 4'b0001;
    while (start_cnt == s0 && n < 50) begin
      cycles(1);
      n++;
    end
    check("abort_start_seen", 32'(start_cnt - s0), 32'd1);
    cycles(5);
    base = done_cnt;
    RESET = 1'b1; eng_abort = 1'b1; req = '0;
    cycles(1);
    check("abort_gnt", 32'(gnt), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    RESET = 1'b0; eng_abort = 1'b0;
    cycles(10);
    check("abort_no_done", 32'(done_cnt - base), 32'd0);
    check("abort_rdata", 32'(rdata), 32'd0);
    eng_lat = 2;
    for (int i = 0; i < NREQ; i++)
      set_slot(i, DMA_DATO, 18'o040000 + 18'(i * 2), 16'(16'h100 + i));
    push_exp(1, DMA_DATO, 18'o040002, 16'h101, rd_of(18'o040002), 0, 0, 5);
    base = done_cnt;
    req = '1;
    wait_dones(base + 1, 100);
    req = '0;
    cycles(4);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ky11_dmaarb.md
Name: ky11_dmaarb

Overview:
- Shares the single KY11 Unibus DMA engine (DATI/DATIP/DATO/DATOB cycles) among NREQ ARM-side requesters, such as emulated disk and tape controllers.
- Selects one requester per cycle by round-robin and loads address, control and data into the engine.
- Starts the engine, waits for it to complete, then returns read data and status to the winner.
- Keeps DATIP→DATO read-modify-write pairs atomic.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ACCTMO, 4, cycles to wait for the engine to leave idle after start before declaring refusal.

Ports:
- CLOCK  in  1  system clock (100MHz).
- RESET  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester cycle request; level, held until done.
- req_addr  in  18*NREQ  packed 18-bit Unibus address per requester.
- req_ctrl  in  2*NREQ  packed cycle type: 0=DATI 1=DATIP 2=DATO 3=DATOB.
- req_wdata  in  16*NREQ  packed write data.
- gnt  out  NREQ  one-hot; requester currently owning the engine.
- done  out  NREQ  one-cycle completion pulse to owner.
- rdata  out  16  read data of the last completed cycle.
- rtimo  out  1  last cycle timed out or was refused.
- rperr  out  1  last read had a parity error.
- armlock  in  1  ARM process holds the DMA lock; blocks new grants.
- dma_start  out  1  one-cycle pulse that starts the engine cycle.
- dma_addr  out  18  address to engine.
- dma_ctrl  out  2  cycle type to engine.
- dma_wdata  out  16  write data to engine.
- dma_busy  in  1  engine state != idle.
- dma_rdata  in  16  engine read data.
- dma_timo  in  1  engine timeout flag.
- dma_perr  in  1  engine parity error flag.

Behaviour:
- Reset: all outputs 0, state IDLE, rr pointer 0, rmw lock clear.
- IDLE:
  - If armlock=1, grant nothing.
  - Else if the rmw lock is set and the locked requester has req=1, grant that requester.
  - Else if the rmw lock is set and the locked requester has req=0, clear the lock, then arbitrate normally in the same cycle.
  - Normal arbitration: the first req set, searching upward from rr+1 modulo NREQ.
  - On a grant: latch the index, set gnt, drive dma_addr/ctrl/wdata from the winner's slice, go to START.
- START: dma_start=1 for exactly one cycle, clear the access counter, go to WAITBUSY. Engine outputs stay stable until DONE.
- WAITBUSY:
  - If dma_busy=1, go to WAITDONE.
  - Else increment the counter; when it reaches ACCTMO, go to DONE with rtimo forced to 1, rdata 0 and rperr 0. This covers the engine being refused or INIT.
- WAITDONE: on dma_busy=0, capture rdata=dma_rdata, rtimo=dma_timo, rperr=dma_perr and go to DONE. No limit here; the engine has its own 10us timeout.
- DONE:
  - done[idx]=1 for one cycle; gnt cleared; rr=idx; state IDLE.
  - The rmw lock is set iff ctrl was DATIP and rtimo=0; otherwise it is cleared.
- Latency: grant→dma_start 1 cycle; engine-idle→done 1 cycle; minimum req→done is 4 cycles plus engine time.
- A requester dropping req mid-cycle does not abort the cycle; done still pulses.
- armlock asserting mid-cycle does not abort; it only blocks the next grant.
- Simultaneous requests resolve by round-robin. A requester re-requesting immediately after done loses to any other pending requester, except while holding the rmw lock.
- RESET mid-cycle returns to IDLE immediately and pulses no done. The engine is reset separately.
- rdata, rtimo and rperr hold their values until the next DONE.

Optional Feature:
- KY11_DMAARB_STATS_EN.
- Defined: adds output stat_cycles[31:0], the count of completed cycles, and stat_timos[15:0], the count of DONE with rtimo=1. Both saturate, clear on RESET, and are readable via the ARM register mux.
- Undefined: neither output exists and no counters are built.

Decomposition:
- Package ky11_pkg holds:
  - cycle-type constants DMA_DATI=2'd0, DMA_DATIP=2'd1, DMA_DATO=2'd2, DMA_DATOB=2'd3;
  - the state enum IDLE/START/WAITBUSY/WAITDONE/DONE;
  - the address width 18 and data width 16.
- One sub-module, ky11_rrpick: combinational round-robin picker taking req, ptr and mask and producing a valid flag and an index.

Test Plan:
- req=0001, req0 DATI 777570, engine busy for 20 cycles then rdata=123456 → dma_start 1 cycle after gnt[0]; done[0] pulses; rdata=123456, rtimo=0.
- req=1111 held for four back-to-back cycles starting from rr=0 → grant order 1,2,3,0.
- req1 DATIP followed by DATO, req2 pending throughout → grants go 1,1,2; the lock clears after the DATO.
- Engine never raises dma_busy → done after ACCTMO+2 cycles with rtimo=1, rdata=0.
- armlock=1 with req=0011 → no dma_start. Deassert armlock → grant within 1 cycle.
- RESET asserted during WAITDONE → next cycle gnt=0, done=0, state IDLE, rr=0.
